dmac_axi_sram_slave: RTL and testbench

- AXI3 slave memory model that sits directly downstream of the 4-channel DMAC AXI master port.
- Consumes AR/R and AW/W/B traffic with 4-bit IDs (ID = DMA channel number) and serves it from an internal word-addressed SRAM array.
- Serves as the DMA source/destination memory in the system bench and in FPGA bring-up.
- Handles interleaved W beats from different channels by tracking one outstanding write burst per ID.

---
 rtl/dmac_axi_pkg.sv | 37 +++
 rtl/dmac_bresp_fifo.sv | 62 ++++++
 rtl/dmac_axi_sram_slave.sv | 222 ++++++++++++++++++++++
 tb/tb_dmac_axi_sram_slave.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmac_axi_pkg.sv
// Shared types and constants for the DMAC AXI3 SRAM slave model.
package dmac_axi_pkg;

  localparam int unsigned AXI_ID_W   = 4;
  localparam int unsigned AXI_ADDR_W = 32;
  localparam int unsigned AXI_DATA_W = 32;
  localparam int unsigned AXI_STRB_W = AXI_DATA_W / 8;
  localparam int unsigned AXI_LEN_W  = 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [2:0] SIZE_WORD   = 3'd2;

  typedef enum logic {
    R_IDLE,
    R_BURST
  } rd_state_e;

  typedef struct packed {
    logic                  pending;
    logic [AXI_ADDR_W-1:0] addr;
    logic [AXI_LEN_W-1:0]  cnt;
    logic [AXI_LEN_W-1:0]  len;
    logic                  err;
  } wr_entry_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0] id;
    logic [1:0]          resp;
  } bresp_t;

  // Bursts are always treated as INCR on 32-bit words.
  function automatic logic [AXI_ADDR_W-1:0] next_beat_addr(input logic [AXI_ADDR_W-1:0] a);
    return a + AXI_ADDR_W'(4);
  endfunction

endpackage

// File: rtl/dmac_bresp_fifo.sv
// Generic synchronous FIFO with valid/ready on both sides; DEPTH must be a power of 2 (>= 2).
module dmac_bresp_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_valid_i,
  output logic             push_ready_o,
  input  logic [WIDTH-1:0] push_data_i,
  output logic             pop_valid_o,
  input  logic             pop_ready_i,
  output logic [WIDTH-1:0] pop_data_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] store_q [DEPTH];
  logic [WIDTH-1:0] store_d [DEPTH];
  logic             full_c;
  logic             empty_c;
  logic             push_c;
  logic             pop_c;

  // Extra pointer MSB distinguishes full from empty.
  assign full_c  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign empty_c = (wr_ptr_q == rd_ptr_q);

  assign push_ready_o = !full_c;
  assign pop_valid_o  = !empty_c;
  assign pop_data_o   = store_q[rd_ptr_q[PTR_W-1:0]];

  assign push_c = push_valid_i && !full_c;
  assign pop_c  = !empty_c && pop_ready_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    for (int i = 0; i < DEPTH; i++) store_d[i] = store_q[i];
    if (push_c) begin
      store_d[wr_ptr_q[PTR_W-1:0]] = push_data_i;
      wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
    end
    if (pop_c) rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) store_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      for (int i = 0; i < DEPTH; i++) store_q[i] <= store_d[i];
    end
  end

endmodule

// File: rtl/dmac_axi_sram_slave.sv
// AXI3 slave SRAM model for the 4-channel DMAC: one read burst at a time,
// one outstanding write burst per ID with interleaved W beats, queued B responses.
module dmac_axi_sram_slave
  import dmac_axi_pkg::*;
#(
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned N_ID     = 4,
  parameter int unsigned BQ_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [AXI_ID_W-1:0]   awid_i,
  input  logic [AXI_ADDR_W-1:0] awaddr_i,
  input  logic [AXI_LEN_W-1:0]  awlen_i,
  input  logic [2:0]            awsize_i,
  input  logic [1:0]            awburst_i,
  input  logic                  awvalid_i,
  output logic                  awready_o,
  input  logic [AXI_ID_W-1:0]   wid_i,
  input  logic [AXI_DATA_W-1:0] wdata_i,
  input  logic [AXI_STRB_W-1:0] wstrb_i,
  input  logic                  wlast_i,
  input  logic                  wvalid_i,
  output logic                  wready_o,
  output logic [AXI_ID_W-1:0]   bid_o,
  output logic [1:0]            bresp_o,
  output logic                  bvalid_o,
  input  logic                  bready_i,
  input  logic [AXI_ID_W-1:0]   arid_i,
  input  logic [AXI_ADDR_W-1:0] araddr_i,
  input  logic [AXI_LEN_W-1:0]  arlen_i,
  input  logic [2:0]            arsize_i,
  input  logic [1:0]            arburst_i,
  input  logic                  arvalid_i,
  output logic                  arready_o,
  output logic [AXI_ID_W-1:0]   rid_o,
  output logic [AXI_DATA_W-1:0] rdata_o,
  output logic [1:0]            rresp_o,
  output logic                  rlast_o,
  output logic                  rvalid_o,
  input  logic                  rready_i
);

  localparam int unsigned IDX_W     = (N_ID > 1) ? $clog2(N_ID) : 1;
  localparam int unsigned MEM_WORDS = 2 ** ADDR_W;

  // A byte address is backed by the array iff no bits above the array span are set.
  function automatic logic addr_in_range(input logic [AXI_ADDR_W-1:0] a);
    return (a >> (ADDR_W + 2)) == '0;
  endfunction

  logic [AXI_DATA_W-1:0] mem [MEM_WORDS];

  wr_entry_t        wr_q [N_ID];
  wr_entry_t        wr_d [N_ID];
  logic [N_ID-1:0]  pend_c;
  logic             aw_id_ok;
  logic             w_id_ok;
  logic [IDX_W-1:0] aw_idx;
  logic [IDX_W-1:0] w_idx;
  logic             aw_hs;
  logic             w_hs;
  wr_entry_t        w_ent;
  logic             w_in_range;
  logic             w_err;
  logic             mem_we;
  logic [ADDR_W-1:0] w_word;

  bresp_t bq_push_data;
  bresp_t bq_head;
  logic   bq_push_valid;
  logic   bq_push_ready;
  logic   bq_pop_valid;

  rd_state_e             rstate_q, rstate_d;
  logic [AXI_ID_W-1:0]   rid_q, rid_d;
  logic [AXI_ADDR_W-1:0] raddr_q, raddr_d;
  logic [AXI_LEN_W-1:0]  rlen_q, rlen_d;
  logic [AXI_LEN_W-1:0]  rcnt_q, rcnt_d;
  logic                  rerr_q, rerr_d;
  logic                  rd_ok;

  logic unused_burst;
  assign unused_burst = ^{awburst_i, arburst_i};

  always_comb begin
    pend_c = '0;
    for (int i = 0; i < N_ID; i++) pend_c[i] = wr_q[i].pending;
  end

  assign aw_id_ok = 32'(awid_i) < N_ID;
  assign w_id_ok  = 32'(wid_i) < N_ID;
  assign aw_idx   = awid_i[IDX_W-1:0];
  assign w_idx    = wid_i[IDX_W-1:0];

  // W beats are held off while the B queue is full, so a push never meets a full queue.
  assign awready_o = aw_id_ok && !pend_c[aw_idx];
  assign wready_o  = w_id_ok && pend_c[w_idx] && bq_push_ready;
  assign aw_hs     = awvalid_i && awready_o;
  assign w_hs      = wvalid_i && wready_o;

  assign w_ent      = wr_q[w_idx];
  assign w_in_range = addr_in_range(w_ent.addr);
  assign w_err      = w_ent.err || !w_in_range || (wlast_i != (w_ent.cnt == w_ent.len));
  assign mem_we     = w_hs && !w_ent.err && w_in_range;
  assign w_word     = w_ent.addr[ADDR_W+1:2];

  assign bq_push_valid     = w_hs && wlast_i;
  assign bq_push_data.id   = wid_i;
  assign bq_push_data.resp = w_err ? RESP_SLVERR : RESP_OKAY;

  // Pending-write table: AW allocates, W beats advance, wlast retires.
  always_comb begin
    for (int i = 0; i < N_ID; i++) wr_d[i] = wr_q[i];
    if (aw_hs) begin
      wr_d[aw_idx] = '{pending: 1'b1, addr: awaddr_i, cnt: '0, len: awlen_i,
                       err: (awsize_i != SIZE_WORD)};
    end
    if (w_hs) begin
      wr_d[w_idx].addr = next_beat_addr(w_ent.addr);
      wr_d[w_idx].cnt  = w_ent.cnt + AXI_LEN_W'(1);
      wr_d[w_idx].err  = w_err;
      if (wlast_i) wr_d[w_idx].pending = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_ID; i++) wr_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_ID; i++) wr_q[i] <= wr_d[i];
    end
  end

  // SRAM array is deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < AXI_STRB_W; b++) begin
        if (wstrb_i[b]) mem[w_word][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  dmac_bresp_fifo #(
    .WIDTH($bits(bresp_t)),
    .DEPTH(BQ_DEPTH)
  ) u_bq (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_valid_i (bq_push_valid),
    .push_ready_o (bq_push_ready),
    .push_data_i  (bq_push_data),
    .pop_valid_o  (bq_pop_valid),
    .pop_ready_i  (bready_i),
    .pop_data_o   (bq_head)
  );

  assign bvalid_o = bq_pop_valid;
  assign bid_o    = bq_pop_valid ? bq_head.id : '0;
  assign bresp_o  = bq_pop_valid ? bq_head.resp : RESP_OKAY;

  // Read burst FSM: one AR at a time, one beat per R handshake.
  always_comb begin
    rstate_d = rstate_q;
    rid_d    = rid_q;
    raddr_d  = raddr_q;
    rlen_d   = rlen_q;
    rcnt_d   = rcnt_q;
    rerr_d   = rerr_q;
    case (rstate_q)
      R_IDLE: begin
        if (arvalid_i) begin
          rid_d    = arid_i;
          raddr_d  = araddr_i;
          rlen_d   = arlen_i;
          rcnt_d   = '0;
          rerr_d   = (arsize_i != SIZE_WORD);
          rstate_d = R_BURST;
        end
      end
      R_BURST: begin
        if (rready_i) begin
          if (rcnt_q == rlen_q) begin
            rstate_d = R_IDLE;
          end else begin
            raddr_d = next_beat_addr(raddr_q);
            rcnt_d  = rcnt_q + AXI_LEN_W'(1);
          end
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rstate_q <= R_IDLE;
      rid_q    <= '0;
      raddr_q  <= '0;
      rlen_q   <= '0;
      rcnt_q   <= '0;
      rerr_q   <= 1'b0;
    end else begin
      rstate_q <= rstate_d;
      rid_q    <= rid_d;
      raddr_q  <= raddr_d;
      rlen_q   <= rlen_d;
      rcnt_q   <= rcnt_d;
      rerr_q   <= rerr_d;
    end
  end

  // Asynchronous array read: a write landing this edge is not visible until the next beat.
  assign rd_ok     = !rerr_q && addr_in_range(raddr_q);
  assign arready_o = (rstate_q == R_IDLE);
  assign rvalid_o  = (rstate_q == R_BURST);
  assign rlast_o   = rvalid_o && (rcnt_q == rlen_q);
  assign rid_o     = rid_q;
  assign rdata_o   = (rvalid_o && rd_ok) ? mem[raddr_q[ADDR_W+1:2]] : '0;
  assign rresp_o   = (rvalid_o && !rd_ok) ? RESP_SLVERR : RESP_OKAY;

endmodule

// File: tb/tb_dmac_axi_sram_slave.sv
// Directed bench for dmac_axi_sram_slave: reads, bursts, interleaving, backpressure, errors, reset.
module tb_dmac_axi_sram_slave;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  awid_i;
  logic [31:0] awaddr_i;
  logic [3:0]  awlen_i;
  logic [2:0]  awsize_i;
  logic [1:0]  awburst_i;
  logic        awvalid_i;
  logic        awready_o;
  logic [3:0]  wid_i;
  logic [31:0] wdata_i;
  logic [3:0]  wstrb_i;
  logic        wlast_i;
  logic        wvalid_i;
  logic        wready_o;
  logic [3:0]  bid_o;
  logic [1:0]  bresp_o;
  logic        bvalid_o;
  logic        bready_i;
  logic [3:0]  arid_i;
  logic [31:0] araddr_i;
  logic [3:0]  arlen_i;
  logic [2:0]  arsize_i;
  logic [1:0]  arburst_i;
  logic        arvalid_i;
  logic        arready_o;
  logic [3:0]  rid_o;
  logic [31:0] rdata_o;
  logic [1:0]  rresp_o;
  logic        rlast_o;
  logic        rvalid_o;
  logic        rready_i;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dmac_axi_sram_slave #(.ADDR_W(12), .N_ID(4), .BQ_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .awid_i(awid_i), .awaddr_i(awaddr_i), .awlen_i(awlen_i), .awsize_i(awsize_i),
    .awburst_i(awburst_i), .awvalid_i(awvalid_i), .awready_o(awready_o),
    .wid_i(wid_i), .wdata_i(wdata_i), .wstrb_i(wstrb_i), .wlast_i(wlast_i),
    .wvalid_i(wvalid_i), .wready_o(wready_o),
    .bid_o(bid_o), .bresp_o(bresp_o), .bvalid_o(bvalid_o), .bready_i(bready_i),
    .arid_i(arid_i), .araddr_i(araddr_i), .arlen_i(arlen_i), .arsize_i(arsize_i),
    .arburst_i(arburst_i), .arvalid_i(arvalid_i), .arready_o(arready_o),
    .rid_o(rid_o), .rdata_o(rdata_o), .rresp_o(rresp_o), .rlast_o(rlast_o),
    .rvalid_o(rvalid_o), .rready_i(rready_i)
  );

  // Channel drivers: present at posedge+1, wait (bounded) for ready at negedge, complete at posedge.
  task automatic aw_send(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size);
    int n = 0;
    awid_i = id; awaddr_i = addr; awlen_i = len; awsize_i = size; awburst_i = 2'b01;
    awvalid_i = 1'b1;
    @(negedge clk);
    while (awready_o !== 1'b1 && n < 50) begin n++; @(negedge clk); end
    if (awready_o !== 1'b1) begin
      errors++; checks++;
      $display("FAIL aw_timeout id=%0d awready=%b required 1", id, awready_o);
    end
    @(posedge clk); #1 awvalid_i = 1'b0;
  endtask

  task automatic w_send(input logic [3:0] id, input logic [31:0] data, input logic [3:0] strb,
                        input logic last);
    int n = 0;
    wid_i = id; wdata_i = data; wstrb_i = strb; wlast_i = last; wvalid_i = 1'b1;
    @(negedge clk);
    while (wready_o !== 1'b1 && n < 50) begin n++; @(negedge clk); end
    if (wready_o !== 1'b1) begin
      errors++; checks++;
      $display("FAIL w_timeout id=%0d wready=%b required 1", id, wready_o);
    end
    @(posedge clk); #1 wvalid_i = 1'b0;
  endtask

  task automatic b_recv(output logic [3:0] id, output logic [1:0] resp);
    int n = 0;
    bready_i = 1'b1;
    @(negedge clk);
    while (bvalid_o !== 1'b1 && n < 50) begin n++; @(negedge clk); end
    if (bvalid_o !== 1'b1) begin
      errors++; checks++;
      $display("FAIL b_timeout bvalid=%b required 1", bvalid_o);
    end
    id = bid_o; resp = bresp_o;
    @(posedge clk); #1 bready_i = 1'b0;
  endtask

  task automatic ar_send(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size);
    int n = 0;
    arid_i = id; araddr_i = addr; arlen_i = len; arsize_i = size; arburst_i = 2'b01;
    arvalid_i = 1'b1;
    @(negedge clk);
    while (arready_o !== 1'b1 && n < 50) begin n++; @(negedge clk); end
    if (arready_o !== 1'b1) begin
      errors++; checks++;
      $display("FAIL ar_timeout id=%0d arready=%b required 1", id, arready_o);
    end
    @(posedge clk); #1 arvalid_i = 1'b0;
  endtask

  task automatic r_recv(output logic [3:0] id, output logic [31:0] data, output logic [1:0] resp,
                        output logic last);
    int n = 0;
    rready_i = 1'b1;
    @(negedge clk);
    while (rvalid_o !== 1'b1 && n < 50) begin n++; @(negedge clk); end
    if (rvalid_o !== 1'b1) begin
      errors++; checks++;
      $display("FAIL r_timeout rvalid=%b required 1", rvalid_o);
    end
    id = rid_o; data = rdata_o; resp = rresp_o; last = rlast_o;
    @(posedge clk); #1 rready_i = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    checks++; if (awready_o !== 1'b1) begin errors++; $display("FAIL rst_awready got %b want 1", awready_o); end
    checks++; if (arready_o !== 1'b1) begin errors++; $display("FAIL rst_arready got %b want 1", arready_o); end
    checks++; if (wready_o !== 1'b0) begin errors++; $display("FAIL rst_wready got %b want 0", wready_o); end
    checks++; if (bvalid_o !== 1'b0) begin errors++; $display("FAIL rst_bvalid got %b want 0", bvalid_o); end
    checks++; if (rvalid_o !== 1'b0) begin errors++; $display("FAIL rst_rvalid got %b want 0", rvalid_o); end
    checks++; if ({rlast_o, rid_o, rdata_o, rresp_o, bid_o, bresp_o} !== '0) begin
      errors++; $display("FAIL rst_payload got rlast=%b rid=%h rdata=%h rresp=%h bid=%h bresp=%h want all 0",
                         rlast_o, rid_o, rdata_o, rresp_o, bid_o, bresp_o);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_read;
    logic [3:0] id; logic [1:0] resp; logic [31:0] data; logic last;
    aw_send(4'd2, 32'h40, 4'd0, 3'd2);
    w_send(4'd2, 32'hDEADBEEF, 4'hF, 1'b1);
    b_recv(id, resp);
    checks++; if (id !== 4'd2 || resp !== 2'b00) begin errors++; $display("FAIL sr_b got id=%0d resp=%0d want 2/0", id, resp); end
    ar_send(4'd2, 32'h40, 4'd0, 3'd2);
    checks++; if (rvalid_o !== 1'b1) begin errors++; $display("FAIL sr_latency rvalid got %b want 1 at t+1", rvalid_o); end
    r_recv(id, data, resp, last);
    checks++; if (id !== 4'd2 || data !== 32'hDEADBEEF || resp !== 2'b00 || last !== 1'b1) begin
      errors++; $display("FAIL sr_r got id=%0d data=%h resp=%0d last=%b want 2/deadbeef/0/1", id, data, resp, last);
    end
    checks++; if (arready_o !== 1'b1 || rvalid_o !== 1'b0) begin
      errors++; $display("FAIL sr_idle got arready=%b rvalid=%b want 1/0", arready_o, rvalid_o);
    end
  endtask

  task automatic test_burst;
    logic [3:0] id; logic [1:0] resp; logic [31:0] data; logic last;
    logic [31:0] exp [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
    aw_send(4'd1, 32'h100, 4'd3, 3'd2);
    for (int i = 0; i < 4; i++) w_send(4'd1, exp[i], 4'hF, i == 3);
    b_recv(id, resp);
    checks++; if (id !== 4'd1 || resp !== 2'b00) begin errors++; $display("FAIL bw_b got id=%0d resp=%0d want 1/0", id, resp); end
    ar_send(4'd1, 32'h100, 4'd3, 3'd2);
    for (int i = 0; i < 4; i++) begin
      r_recv(id, data, resp, last);
      checks++; if (id !== 4'd1 || data !== exp[i] || resp !== 2'b00 || last !== (i == 3)) begin
        errors++; $display("FAIL bw_r%0d got id=%0d data=%h resp=%0d last=%b want 1/%h/0/%0d", i, id, data, resp, last, exp[i], i == 3);
      end
    end
  endtask

  task automatic test_interleave;
    logic [3:0] id; logic [1:0] resp; logic [31:0] data; logic last;
    aw_send(4'd0, 32'h200, 4'd1, 3'd2);
    aw_send(4'd3, 32'h300, 4'd1, 3'd2);
    w_send(4'd0, 32'hA0A0_0000, 4'hF, 1'b0);
    w_send(4'd3, 32'hB3B3_0000, 4'hF, 1'b0);
    w_send(4'd0, 32'hA0A0_0001, 4'hF, 1'b1);
    w_send(4'd3, 32'hB3B3_0001, 4'hF, 1'b1);
    b_recv(id, resp);
    checks++; if (id !== 4'd0 || resp !== 2'b00) begin errors++; $display("FAIL il_b0 got id=%0d resp=%0d want 0/0", id, resp); end
    b_recv(id, resp);
    checks++; if (id !== 4'd3 || resp !== 2'b00) begin errors++; $display("FAIL il_b1 got id=%0d resp=%0d want 3/0", id, resp); end
    ar_send(4'd0, 32'h200, 4'd1, 3'd2);
    for (int i = 0; i < 2; i++) begin
      r_recv(id, data, resp, last);
      checks++; if (data !== (32'hA0A0_0000 + 32'(i))) begin errors++; $display("FAIL il_r0_%0d got %h want %h", i, data, 32'hA0A0_0000 + 32'(i)); end
    end
    ar_send(4'd3, 32'h300, 4'd1, 3'd2);
    for (int i = 0; i < 2; i++) begin
      r_recv(id, data, resp, last);
      checks++; if (data !== (32'hB3B3_0000 + 32'(i)) || id !== 4'd3) begin
        errors++; $display("FAIL il_r3_%0d got id=%0d data=%h want 3/%h", i, id, data, 32'hB3B3_0000 + 32'(i));
      end
    end
  endtask

  task automatic test_backpressure;
    logic [3:0] id; logic [1:0] resp; logic [31:0] data; logic last;
    logic [3:0] exp_id [4] = '{4'd1, 4'd2, 4'd3, 4'd0};
    ar_send(4'd1, 32'h100, 4'd3, 3'd2);
    r_recv(id, data, resp, last);
    checks++; if (data !== 32'h11) begin errors++; $display("FAIL bp_r0 got %h want 11", data); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++; if (rvalid_o !== 1'b1 || rdata_o !== 32'h22 || rid_o !== 4'd1 || rlast_o !== 1'b0) begin
        errors++; $display("FAIL bp_hold%0d got v=%b data=%h id=%0d last=%b want 1/22/1/0", k, rvalid_o, rdata_o, rid_o, rlast_o);
      end
    end
    @(posedge clk); #1;
    for (int i = 1; i < 4; i++) begin
      r_recv(id, data, resp, last);
      checks++; if (data !== 32'h11 * 32'(i + 1) || last !== (i == 3)) begin
        errors++; $display("FAIL bp_r%0d got data=%h last=%b want %h/%0d", i, data, last, 32'h11 * 32'(i + 1), i == 3);
      end
    end
    for (int i = 0; i < 4; i++) begin
      aw_send(4'(i), 32'h400 + 32'(4 * i), 4'd0, 3'd2);
      w_send(4'(i), 32'h5000 + 32'(i), 4'hF, 1'b1);
    end
    aw_send(4'd0, 32'h410, 4'd0, 3'd2);
    wid_i = 4'd0; wdata_i = 32'h5555; wstrb_i = 4'hF; wlast_i = 1'b1; wvalid_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (wready_o !== 1'b0 || bvalid_o !== 1'b1) begin
        errors++; $display("FAIL bp_full%0d got wready=%b bvalid=%b want 0/1", k, wready_o, bvalid_o);
      end
    end
    bready_i = 1'b1;
    checks++; if (bid_o !== 4'd0) begin errors++; $display("FAIL bp_head got bid=%0d want 0", bid_o); end
    @(posedge clk); #1 bready_i = 1'b0;
    w_send(4'd0, 32'h5555, 4'hF, 1'b1);
    for (int i = 0; i < 4; i++) begin
      b_recv(id, resp);
      checks++; if (id !== exp_id[i] || resp !== 2'b00) begin
        errors++; $display("FAIL bp_b%0d got id=%0d resp=%0d want %0d/0", i, id, resp, exp_id[i]);
      end
    end
    ar_send(4'd0, 32'h410, 4'd0, 3'd2);
    r_recv(id, data, resp, last);
    checks++; if (data !== 32'h5555) begin errors++; $display("FAIL bp_rd got %h want 5555", data); end
  endtask

  task automatic test_errors;
    logic [3:0] id; logic [1:0] resp; logic [31:0] data; logic last;
    ar_send(4'd5, 32'h4000, 4'd0, 3'd2);
    r_recv(id, data, resp, last);
    checks++; if (id !== 4'd5 || data !== 32'h0 || resp !== 2'b10 || last !== 1'b1) begin
      errors++; $display("FAIL er_oor_r got id=%0d data=%h resp=%0d last=%b want 5/0/2/1", id, data, resp, last);
    end
    aw_send(4'd2, 32'h500, 4'd1, 3'd2);
    w_send(4'd2, 32'h1, 4'hF, 1'b1);
    b_recv(id, resp);
    checks++; if (id !== 4'd2 || resp !== 2'b10) begin errors++; $display("FAIL er_early got id=%0d resp=%0d want 2/2", id, resp); end
    checks++; if (awready_o !== 1'b1) begin errors++; $display("FAIL er_early_free awready got %b want 1", awready_o); end
    aw_send(4'd3, 32'h600, 4'd0, 3'd2);
    w_send(4'd3, 32'h12345678, 4'hF, 1'b1);
    b_recv(id, resp);
    aw_send(4'd3, 32'h600, 4'd0, 3'd1);
    w_send(4'd3, 32'hFFFFFFFF, 4'hF, 1'b1);
    b_recv(id, resp);
    checks++; if (id !== 4'd3 || resp !== 2'b10) begin errors++; $display("FAIL er_size_b got id=%0d resp=%0d want 3/2", id, resp); end
    ar_send(4'd3, 32'h600, 4'd0, 3'd2);
    r_recv(id, data, resp, last);
    checks++; if (data !== 32'h12345678 || resp !== 2'b00) begin errors++; $display("FAIL er_size_mem got %h/%0d want 12345678/0", data, resp); end
    aw_send(4'd3, 32'h600, 4'd0, 3'd2);
    w_send(4'd3, 32'hAABBCCDD, 4'b0101, 1'b1);
    b_recv(id, resp);
    ar_send(4'd3, 32'h600, 4'd0, 3'd2);
    r_recv(id, data, resp, last);
    checks++; if (data !== 32'h12BB56DD) begin errors++; $display("FAIL er_strb got %h want 12bb56dd", data); end
    aw_send(4'd1, 32'h3FFC, 4'd1, 3'd2);
    w_send(4'd1, 32'hCAFE0001, 4'hF, 1'b0);
    w_send(4'd1, 32'hCAFE0002, 4'hF, 1'b1);
    b_recv(id, resp);
    checks++; if (resp !== 2'b10) begin errors++; $display("FAIL er_edge_b got resp=%0d want 2", resp); end
    ar_send(4'd1, 32'h3FFC, 4'd1, 3'd2);
    r_recv(id, data, resp, last);
    checks++; if (data !== 32'hCAFE0001 || resp !== 2'b00 || last !== 1'b0) begin
      errors++; $display("FAIL er_edge_r0 got %h/%0d/%b want cafe0001/0/0", data, resp, last);
    end
    r_recv(id, data, resp, last);
    checks++; if (data !== 32'h0 || resp !== 2'b10 || last !== 1'b1) begin
      errors++; $display("FAIL er_edge_r1 got %h/%0d/%b want 0/2/1", data, resp, last);
    end
    ar_send(4'd4, 32'h600, 4'd0, 3'd1);
    r_recv(id, data, resp, last);
    checks++; if (data !== 32'h0 || resp !== 2'b10) begin errors++; $display("FAIL er_arsize got %h/%0d want 0/2", data, resp); end
  endtask

  task automatic test_reset_mid;
    logic [3:0] id; logic [1:0] resp; logic [31:0] data; logic last;
    ar_send(4'd1, 32'h100, 4'd3, 3'd2);
    r_recv(id, data, resp, last);
    aw_send(4'd2, 32'h700, 4'd3, 3'd2);
    w_send(4'd2, 32'h77, 4'hF, 1'b0);
    wid_i = 4'd2; wlast_i = 1'b0; wvalid_i = 1'b1; awid_i = 4'd2;
    @(negedge clk);
    checks++; if (wready_o !== 1'b1 || rvalid_o !== 1'b1) begin
      errors++; $display("FAIL rm_pre got wready=%b rvalid=%b want 1/1", wready_o, rvalid_o);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (rvalid_o !== 1'b0 || rlast_o !== 1'b0 || rdata_o !== 32'h0 || rid_o !== 4'd0 || arready_o !== 1'b1) begin
      errors++; $display("FAIL rm_r got v=%b last=%b data=%h id=%0d arready=%b want 0/0/0/0/1", rvalid_o, rlast_o, rdata_o, rid_o, arready_o);
    end
    checks++; if (wready_o !== 1'b0 || bvalid_o !== 1'b0 || awready_o !== 1'b1) begin
      errors++; $display("FAIL rm_w got wready=%b bvalid=%b awready=%b want 0/0/1", wready_o, bvalid_o, awready_o);
    end
    wvalid_i = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    aw_send(4'd2, 32'h700, 4'd0, 3'd2);
    w_send(4'd2, 32'h7777, 4'hF, 1'b1);
    b_recv(id, resp);
    checks++; if (id !== 4'd2 || resp !== 2'b00) begin errors++; $display("FAIL rm_b got id=%0d resp=%0d want 2/0", id, resp); end
    checks++; if (bvalid_o !== 1'b0) begin errors++; $display("FAIL rm_stale_b got bvalid=%b want 0", bvalid_o); end
    ar_send(4'd1, 32'h700, 4'd0, 3'd2);
    r_recv(id, data, resp, last);
    checks++; if (id !== 4'd1 || data !== 32'h7777 || last !== 1'b1) begin
      errors++; $display("FAIL rm_r_after got id=%0d data=%h last=%b want 1/7777/1", id, data, last);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    awid_i = '0; awaddr_i = '0; awlen_i = '0; awsize_i = '0; awburst_i = '0; awvalid_i = 1'b0;
    wid_i = '0; wdata_i = '0; wstrb_i = '0; wlast_i = 1'b0; wvalid_i = 1'b0; bready_i = 1'b0;
    arid_i = '0; araddr_i = '0; arlen_i = '0; arsize_i = '0; arburst_i = '0; arvalid_i = 1'b0;
    rready_i = 1'b0;
    repeat (3) @(posedge clk);
    test_reset();
    test_single_read();
    test_burst();
    test_interleave();
    test_backpressure();
    test_errors();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
